sd_cmd_resp_rx: RTL and testbench

Receives the card-to-host response frame on the SD CMD line after the host command transmitter has sent its end bit. Hunts for the start bit within the NCR window, then shifts in a 48-bit (R1/R3/R4/R6/R7) or 136-bit (R2) frame. Checks the direction bit, CRC7 and end bit, and presents the decoded fields to the command sequencer. Samples only on strobes aligned to the host-generated sdio_clk rising edge.

---
 rtl/sd_cmd_resp_rx_if.sv | 27 ++
 rtl/sd_cmd_resp_rx.sv | 120 ++++++++++++
 tb/tb_sd_cmd_resp_rx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_resp_rx_if.sv
// sd_cmd_resp_rx_if: sequencer/PHY-side bundle of the SD CMD response receiver
// slave (receiver) inputs: sd_clk_rise, sdio_cmd_i, arm, resp_long, crc_chk
// slave outputs: busy, resp_done, resp_index, resp_arg, resp_data, crc_err, end_err, dir_err, timeout
interface sd_cmd_resp_rx_if;
  logic         sd_clk_rise;
  logic         sdio_cmd_i;
  logic         arm;
  logic         resp_long;
  logic         crc_chk;
  logic         busy;
  logic         resp_done;
  logic [5:0]   resp_index;
  logic [31:0]  resp_arg;
  logic [119:0] resp_data;
  logic         crc_err;
  logic         end_err;
  logic         dir_err;
  logic         timeout;
  modport master (
    output sd_clk_rise, sdio_cmd_i, arm, resp_long, crc_chk,
    input  busy, resp_done, resp_index, resp_arg, resp_data, crc_err, end_err, dir_err, timeout
  );
  modport slave (
    input  sd_clk_rise, sdio_cmd_i, arm, resp_long, crc_chk,
    output busy, resp_done, resp_index, resp_arg, resp_data, crc_err, end_err, dir_err, timeout
  );
endinterface

// File: rtl/sd_cmd_resp_rx.sv
// sd_cmd_resp_rx: SD CMD-line response receiver (start hunt, 48/136-bit frame, CRC7/end/dir checks); ports clk, rst_n (async active-low), b (sd_cmd_resp_rx_if.slave); RESP_LONG_EN enables 136-bit R2
module sd_cmd_resp_rx #(
  parameter int NCR_MAX = 64,
  parameter int TO_W    = 8
) (
  input logic             clk,
  input logic             rst_n,
  sd_cmd_resp_rx_if.slave b
);
`ifdef RESP_LONG_EN
  localparam int   SW = 127;
  localparam logic LE = 1'b1;
  logic [119:0] data_q;
  assign b.resp_data = data_q;
`else
  localparam int   SW = 45;
  localparam logic LE = 1'b0;
  assign b.resp_data = '0;
`endif
  typedef enum logic [1:0] {IDLE, WAIT_START, RECV, DONE} state_t;
  state_t          state_q;
  logic            long_q, chk_q, busy_q, done_q, crc_err_q, end_err_q, dir_err_q, timeout_q;
  logic [TO_W-1:0] to_q;
  logic [7:0]      cnt_q;
  logic [SW-1:0]   sr_q;
  logic [6:0]      crc_q;
  logic [5:0]      index_q;
  logic [31:0]     arg_q;
  logic            fb;
  assign fb           = crc_q[6] ^ b.sdio_cmd_i;
  assign b.busy       = busy_q;
  assign b.resp_done  = done_q;
  assign b.resp_index = index_q;
  assign b.resp_arg   = arg_q;
  assign b.crc_err    = crc_err_q;
  assign b.end_err    = end_err_q;
  assign b.dir_err    = dir_err_q;
  assign b.timeout    = timeout_q;
  // cnt_q equals the frame bit position being sampled; sr_q only keeps frame bits
  // [top:1] (top = 45 short / 127 long) so sr_q[k-1] holds frame bit k at the end strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      long_q    <= 1'b0;
      chk_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      dir_err_q <= 1'b0;
      timeout_q <= 1'b0;
      to_q      <= '0;
      cnt_q     <= '0;
      sr_q      <= '0;
      crc_q     <= '0;
      index_q   <= '0;
      arg_q     <= '0;
`ifdef RESP_LONG_EN
      data_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (b.arm) begin
          state_q   <= WAIT_START;
          long_q    <= LE & b.resp_long;
          chk_q     <= b.crc_chk;
          busy_q    <= 1'b1;
          crc_err_q <= 1'b0;
          end_err_q <= 1'b0;
          dir_err_q <= 1'b0;
          timeout_q <= 1'b0;
          to_q      <= '0;
          sr_q      <= '0;
          crc_q     <= '0;
          index_q   <= '0;
          arg_q     <= '0;
`ifdef RESP_LONG_EN
          data_q    <= '0;
`endif
        end
        // a zero start bit is tested first so it wins over the final NCR strobe
        WAIT_START: if (b.sd_clk_rise) begin
          if (!b.sdio_cmd_i) begin
            state_q <= RECV;
            cnt_q   <= long_q ? 8'd134 : 8'd46;
          end else if (to_q == TO_W'(NCR_MAX - 1)) begin
            state_q   <= DONE;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end else
            to_q <= to_q + 1'b1;
        end
        RECV: if (b.sd_clk_rise) begin
          if (cnt_q == (long_q ? 8'd134 : 8'd46)) dir_err_q <= b.sdio_cmd_i;
          if (cnt_q >= 8'd8 && cnt_q <= (long_q ? 8'd127 : 8'd47))
            crc_q <= {crc_q[5:0], 1'b0} ^ ({7{fb}} & 7'h09);
          if (cnt_q != 8'd0 && cnt_q <= (long_q ? 8'd127 : 8'd45))
            sr_q <= {sr_q[SW-2:0], b.sdio_cmd_i};
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd0) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            end_err_q <= ~b.sdio_cmd_i;
            crc_err_q <= chk_q & (crc_q != sr_q[6:0]);
            index_q   <= long_q ? 6'h3F : sr_q[44:39];
            arg_q     <= long_q ? 32'h0 : sr_q[38:7];
`ifdef RESP_LONG_EN
            if (long_q) data_q <= sr_q[126:7];
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// tb_sd_cmd_resp_rx: randomized scoreboard bench for sd_cmd_resp_rx against a polynomial-division CRC7 model
module tb_sd_cmd_resp_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sd_cmd_resp_rx_if b();
  sd_cmd_resp_rx #(.NCR_MAX(64), .TO_W(8)) dut (.clk(clk), .rst_n(rst_n), .b(b));
  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [119:0] data;
    logic         ce, ee, de, to;
  } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  time  last_strobe = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // remainder of msg(x)*x^7 divided by x^7+x^3+1, msg in the low n bits
  function automatic logic [6:0] crc7_of(input logic [119:0] msg, input int n);
    logic [126:0] r;
    r = 127'(msg) << 7;
    for (int i = n + 6; i >= 7; i--)
      if (r[i]) r = r ^ (127'h89 << (i - 7));
    return r[6:0];
  endfunction
  task automatic send_bit(input logic v);
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1 b.sdio_cmd_i = v;
    b.sd_clk_rise = 1'b1;
    @(posedge clk);
    last_strobe = $time;
    #1 b.sd_clk_rise = 1'b0;
  endtask
  task automatic arm_rx(input logic l, input logic c);
    @(posedge clk);
    #1 b.arm = 1'b1;
    b.resp_long = l;
    b.crc_chk = c;
    @(posedge clk);
    #1 b.arm = 1'b0;
  endtask
  task automatic send_frame(input logic [135:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(f[i]);
  endtask
  task automatic raw_txn(input logic [135:0] f, input int n, input logic l, input logic c,
                         input int idle, input exp_t e);
    arm_rx(l, c);
    q.push_back(e);
    repeat (idle) send_bit(1'b1);
    send_frame(f, n);
  endtask
  task automatic short_rand();
    logic [5:0] idx;
    logic [31:0] arg;
    logic dir, en, c;
    logic [6:0] bad, crc;
    idx = 6'($urandom);
    arg = $urandom;
    dir = ($urandom_range(0, 7) == 0);
    en  = ($urandom_range(0, 7) != 0);
    c   = 1'($urandom_range(0, 1));
    bad = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
    crc = crc7_of(120'({1'b0, dir, idx, arg}), 40) ^ bad;
    raw_txn(136'({1'b0, dir, idx, arg, crc, en}), 48, 1'b0, c, $urandom_range(0, 20),
            '{idx, arg, 120'h0, c && bad != 0, !en, dir, 1'b0});
  endtask
`ifdef RESP_LONG_EN
  task automatic long_txn(input logic [119:0] d, input logic dir, input logic en,
                          input logic [6:0] bad, input logic c);
    logic [6:0] crc;
    crc = crc7_of(d, 120) ^ bad;
    raw_txn({1'b0, dir, 6'h3F, d, crc, en}, 136, 1'b1, c, $urandom_range(0, 20),
            '{6'h3F, 32'h0, d, c && bad != 0, !en, dir, 1'b0});
  endtask
`endif
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (b.resp_done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got resp_done=1 expected no pending response");
        end else begin
          e = q.pop_front();
          chk("resp_index", b.resp_index, e.idx);
          chk("resp_arg", b.resp_arg, e.arg);
          chk("resp_data", b.resp_data, e.data);
          chk("crc_err", b.crc_err, e.ce);
          chk("end_err", b.end_err, e.ee);
          chk("dir_err", b.dir_err, e.de);
          chk("timeout", b.timeout, e.to);
          chk("done_latency", $time - last_strobe, 5);
          chk("busy_at_done", b.busy, 1);
          @(negedge clk);
          chk("busy_fall", b.busy, 0);
          chk("done_one_clk", b.resp_done, 0);
        end
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end
  initial begin
    b.sd_clk_rise = 1'b0;
    b.sdio_cmd_i = 1'b1;
    b.arm = 1'b0;
    b.resp_long = 1'b0;
    b.crc_chk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", b.busy, 0);
    chk("reset_done", b.resp_done, 0);
    chk("reset_outs", {b.resp_index, b.resp_arg, b.crc_err, b.end_err, b.dir_err, b.timeout}, 0);
    chk("reset_data", b.resp_data, 0);
    rst_n = 1'b1;
    raw_txn(136'h08_0000_01AA_13, 48, 1'b0, 1'b1, 3, '{6'h08, 32'h1AA, 120'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    raw_txn(136'h08_0000_01AA_15, 48, 1'b0, 1'b1, 3, '{6'h08, 32'h1AA, 120'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    raw_txn(136'h3F_9020_0000_FF, 48, 1'b0, 1'b0, 5, '{6'h3F, 32'h90200000, 120'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    raw_txn(136'h48_0000_01AA_12, 48, 1'b0, 1'b0, 2, '{6'h08, 32'h1AA, 120'h0, 1'b0, 1'b1, 1'b1, 1'b0});
    arm_rx(1'b0, 1'b1);
    arm_rx(1'b0, 1'b0);
    q.push_back('{6'h08, 32'h1AA, 120'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    send_frame(136'h08_0000_01AA_15, 48);
    arm_rx(1'b0, 1'b1);
    q.push_back('{6'h00, 32'h0, 120'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    repeat (64) send_bit(1'b1);
    raw_txn(136'h08_0000_01AA_13, 48, 1'b0, 1'b1, 63, '{6'h08, 32'h1AA, 120'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    arm_rx(1'b0, 1'b1);
    repeat (2) send_bit(1'b1);
    for (int i = 47; i >= 28; i--) send_bit(i == 46);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", b.busy, 0);
    chk("rst_mid_outs", {b.resp_done, b.resp_index, b.resp_arg, b.crc_err, b.end_err, b.dir_err, b.timeout}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    raw_txn(136'h08_0000_01AA_13, 48, 1'b0, 1'b1, 1, '{6'h08, 32'h1AA, 120'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (25) short_rand();
`ifdef RESP_LONG_EN
    long_txn(120'h0123456789ABCDEF0123456789ABEF, 1'b0, 1'b1, 7'd0, 1'b1);
    repeat (6)
      long_txn({$urandom, $urandom, $urandom, 24'($urandom)}, ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 5) != 0),
               ($urandom_range(0, 2) == 0) ? 7'($urandom_range(1, 127)) : 7'd0,
               1'($urandom_range(0, 1)));
`endif
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
